// File: rtl/clusterv_sram_arb.sv
// clusterv_sram_arb
//   Round-robin arbiter that lets N Wishbone initiators share one single-port
//   SRAM. Each transfer takes three cycles: IDLE picks a winner, ACCESS
//   strobes the SRAM for one cycle, and ACK returns the acknowledge. The read
//   data arrives from the SRAM in the ACK cycle.
//
// Ports
//   clock, reset            single clock, asynchronous active-low reset
//   t_adr/t_dat_w/t_sel     per-initiator byte address, write data, byte selects
//   t_cyc/t_stb/t_we        per-initiator Wishbone cycle, strobe, write enable
//   t_dat_r/t_ack/t_err     per-initiator read data, acknowledge, error (tied 0)
//   i_addr/i_write_data     SRAM word address and write data
//   i_write_en/i_read_en    SRAM strobes, i_read_data valid one cycle after i_read_en
//   i_byte_en               SRAM byte enables
//
// State   | meaning
// IDLE    | wait for a request, register round-robin winner in grant
// ACCESS  | drive SRAM for the granted initiator (skipped if it dropped)
// ACK     | acknowledge the granted initiator, return read data
module clusterv_sram_arb #(
  parameter int N_INITIATORS   = 4,
  parameter int SRAM_ADR_WIDTH = 12,
  parameter int DAT_WIDTH      = 32
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [32*N_INITIATORS-1:0]             t_adr,
  input  logic [DAT_WIDTH*N_INITIATORS-1:0]      t_dat_w,
  input  logic [(DAT_WIDTH/8)*N_INITIATORS-1:0]  t_sel,
  input  logic [N_INITIATORS-1:0]                t_cyc,
  input  logic [N_INITIATORS-1:0]                t_stb,
  input  logic [N_INITIATORS-1:0]                t_we,
  output logic [DAT_WIDTH*N_INITIATORS-1:0]      t_dat_r,
  output logic [N_INITIATORS-1:0]                t_ack,
  output logic [N_INITIATORS-1:0]                t_err,
  output logic [SRAM_ADR_WIDTH-1:0]              i_addr,
  output logic [DAT_WIDTH-1:0]                   i_write_data,
  input  logic [DAT_WIDTH-1:0]                   i_read_data,
  output logic                                   i_write_en,
  output logic                                   i_read_en,
  output logic [(DAT_WIDTH/8)-1:0]               i_byte_en
);

  localparam int SEL_W = DAT_WIDTH / 8;
  localparam int GW    = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;

  logic [N_INITIATORS-1:0]   req;
  logic [SRAM_ADR_WIDTH-1:0] adr_arr [N_INITIATORS];
  logic [DAT_WIDTH-1:0]      dat_arr [N_INITIATORS];
  logic [SEL_W-1:0]          sel_arr [N_INITIATORS];

  // Address decode is the interconnect's job: only the word-address bits
  // of t_adr matter here, the rest is deliberately ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^t_adr;

  for (genvar k = 0; k < N_INITIATORS; k++) begin : g_split
    assign adr_arr[k] = t_adr[k*32+2 +: SRAM_ADR_WIDTH];
    assign dat_arr[k] = t_dat_w[k*DAT_WIDTH +: DAT_WIDTH];
    assign sel_arr[k] = t_sel[k*SEL_W +: SEL_W];
  end

  assign req = t_cyc & t_stb;

  logic gnt_req;
  assign gnt_req = req[grant_q];

  // Round-robin search starting one past the last served initiator.
  logic [GW-1:0] rr_win;
  logic [GW-1:0] rr_idx;
  logic          rr_found;

  always_comb begin
    rr_win   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= N_INITIATORS; i++) begin
      rr_idx = GW'((int'(last_grant_q) + i) % N_INITIATORS);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_INITIATORS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_win;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (gnt_req) begin
          state_d = ACK;
        end else begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      ACK: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset clears every strobe and ack in the same instant.
  always_comb begin
    i_addr       = '0;
    i_write_data = '0;
    i_write_en   = 1'b0;
    i_read_en    = 1'b0;
    i_byte_en    = '0;
    t_ack        = '0;
    t_dat_r      = '0;
    if (state_q == ACCESS && gnt_req) begin
      i_addr       = adr_arr[grant_q];
      i_write_data = dat_arr[grant_q];
      if (t_we[grant_q]) begin
        i_write_en = 1'b1;
        i_byte_en  = sel_arr[grant_q];
      end else begin
        i_read_en = 1'b1;
        i_byte_en = '1;
      end
    end
    if (state_q == ACK && gnt_req) begin
      t_ack[grant_q] = 1'b1;
      for (int k = 0; k < N_INITIATORS; k++) begin
        if (GW'(k) == grant_q) t_dat_r[k*DAT_WIDTH +: DAT_WIDTH] = i_read_data;
      end
    end
  end

  assign t_err = '0;

endmodule

// File: doc/clusterv_sram_arb.md
CLUSTERV_SRAM_ARB -- requirements
Module: clusterv_sram_arb

Interface
REQ-001 Parameter N_INITIATORS, default 4: number of Wishbone initiators sharing the main SRAM.
REQ-002 Parameter SRAM_ADR_WIDTH, default 12: SRAM word-address width.
REQ-003 Parameter DAT_WIDTH, default 32: data width. The byte-enable width is DAT_WIDTH/8.
REQ-004 Port clock, input, 1: single clock for the block. All logic SHALL be in this clock domain.
REQ-005 Port reset, input, 1: asynchronous reset, active-low.
REQ-006 Port t_adr, input, 32*N: per-initiator byte address.
REQ-007 Port t_dat_w, input, DAT_WIDTH*N: per-initiator write data.
REQ-008 Port t_sel, input, 4*N: per-initiator byte selects.
REQ-009 Ports t_cyc, t_stb and t_we, input, N each: per-initiator Wishbone cycle, strobe and write-enable.
REQ-010 Port t_dat_r, output, DAT_WIDTH*N: per-initiator read data.
REQ-011 Ports t_ack and t_err, output, N each: per-initiator acknowledge and error.
REQ-012 Port i_addr, output, SRAM_ADR_WIDTH: SRAM word address.
REQ-013 Port i_write_data, output, DAT_WIDTH: SRAM write data.
REQ-014 Port i_read_data, input, DAT_WIDTH: SRAM read data, valid one cycle after i_read_en.
REQ-015 Ports i_write_en and i_read_en, output, 1 each: SRAM write and read strobes.
REQ-016 Port i_byte_en, output, 4: SRAM byte enables.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and ACK.
REQ-018 IDLE: a request from initiator k is t_cyc[k] and t_stb[k] both high. When any request is present, the block SHALL register the winner in grant and go to ACCESS.
REQ-019 The winner SHALL be chosen round-robin: first requester found searching upward from last_grant+1 modulo N.
REQ-020 ACCESS, granted request still present: for exactly one cycle the block SHALL drive i_addr = t_adr[grant][SRAM_ADR_WIDTH+1:2] and i_write_data = t_dat_w[grant].
REQ-021 In that ACCESS cycle, a write SHALL assert i_write_en with i_byte_en = t_sel[grant].
REQ-022 In that ACCESS cycle, a read SHALL assert i_read_en with i_byte_en = 4'hF. The state SHALL then become ACK.
REQ-023 ACCESS, granted request dropped: no SRAM strobe, no ack, return to IDLE. last_grant SHALL be updated to grant.
REQ-024 ACK: t_ack[grant] SHALL be high for exactly one cycle, and t_dat_r[grant] = i_read_data in that cycle. The block SHALL then set last_grant = grant and return to IDLE.
REQ-025 ACK with the granted request dropped: t_ack SHALL be suppressed and any SRAM write already performed SHALL stand. The block SHALL still return to IDLE.
REQ-026 Latency from request sampled in IDLE to ack SHALL be 2 cycles. Maximum throughput SHALL be one transfer per 3 cycles.
REQ-027 Outside ACCESS, i_write_en, i_read_en and i_byte_en SHALL be 0. t_ack SHALL be 0 outside ACK. At most one t_ack bit SHALL be high in any cycle.
REQ-028 t_err SHALL be constant 0.
REQ-029 Address bits t_adr[1:0] and bits above SRAM_ADR_WIDTH+1 SHALL be ignored; address decode belongs to the interconnect.
REQ-030 A write with t_sel = 0 SHALL still pulse i_write_en with i_byte_en = 0 and be acked normally.
REQ-031 t_dat_r of non-granted initiators SHALL be 0.
REQ-032 A request arriving while another is in ACCESS or ACK SHALL wait. It SHALL NOT be lost as long as the initiator holds cyc and stb.
REQ-033 With N requesters continuously active, each SHALL be served exactly once per N transfers.

Reset
REQ-034 Reset assertion SHALL immediately force: state IDLE, grant 0, last_grant N-1 (initiator 0 has first priority), and all outputs 0.
REQ-035 Reset asserted mid-ACCESS or mid-ACK SHALL abort the transfer with no ack. An SRAM strobe SHALL NOT persist past reset assertion.
REQ-036 After reset deassertion, the first request SHALL be sampled on the first rising clock edge.

Verification
REQ-037 Single write, then read: init 1 writes 0xDEADBEEF to adr 0x80000010 with sel F → i_addr = 4, i_write_en pulse, ack at cycle 2. Init 1 then reads 0x80000010 → t_dat_r[1] = 0xDEADBEEF.
REQ-038 Byte write: sel = 4'b0010, data 0x0000AB00 to a word holding 0xDEADBEEF → readback 0xDEADABEF.
REQ-039 Contention: all 4 initiators request at once after reset → grant order 0,1,2,3,0,… and no double acks.
REQ-040 Abort: init 2 drops cyc during ACCESS → no strobe, no ack. The next grant SHALL go to init 3 if it is requesting.
REQ-041 Reset during ACK of init 0 → t_ack stays 0. After release, init 0 requesting again is granted first.
REQ-042 Zero-sel write: sel = 0 → ack returned and memory word unchanged on readback.
